hlsm_batch_driver: RTL

//  Initiator side of the Start/Done kernel handshake used by the HLSM datapath blocks.

---
 rtl/hlsm_batch_driver_if.sv | 27 ++
 rtl/hlsm_batch_driver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hlsm_batch_driver_if.sv
// Start/Done kernel handshake bundle between the batch driver (master) and one
// HLSM4-style kernel (slave).
interface hlsm_batch_driver_if #(
  parameter int WIDTH = 32
) ();
  logic                    k_rst;
  logic                    k_start;
  logic                    k_done;
  logic                    k_t;
  logic signed [WIDTH-1:0] k_a;
  logic signed [WIDTH-1:0] k_b;
  logic signed [WIDTH-1:0] k_c;
  logic signed [WIDTH-1:0] k_zero;
  logic signed [WIDTH-1:0] k_one;
  logic signed [WIDTH-1:0] k_z;
  logic signed [WIDTH-1:0] k_x;

  modport master (
    output k_rst, k_start, k_a, k_b, k_c, k_zero, k_one, k_t,
    input  k_done, k_z, k_x
  );

  modport slave (
    input  k_rst, k_start, k_a, k_b, k_c, k_zero, k_one, k_t,
    output k_done, k_z, k_x
  );
endinterface

// File: rtl/hlsm_batch_driver.sv
// Batch initiator: holds an operand table and runs each entry through one kernel
// (reset, start, wait for done, capture), storing results in a readable table.
module hlsm_batch_driver #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_go,
  input  logic [AW:0]             i_count,
  input  logic                    i_wr_en,
  input  logic [AW-1:0]           i_wr_addr,
  input  logic signed [WIDTH-1:0] i_wr_a,
  input  logic signed [WIDTH-1:0] i_wr_b,
  input  logic signed [WIDTH-1:0] i_wr_c,
  input  logic                    i_wr_t,
  input  logic [AW-1:0]           i_rd_addr,
  output logic signed [WIDTH-1:0] o_rd_z,
  output logic signed [WIDTH-1:0] o_rd_x,
  output logic                    o_busy,
  output logic                    o_batch_done,
  output logic                    o_timeout,
  hlsm_batch_driver_if.master     kif
);
  localparam int            WW      = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_N = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0] TO_N    = WW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, KRST, ISSUE, WAIT, STORE, FINISH, ERR} state_t;

  state_t                  r_state;
  logic [AW-1:0]           r_idx;
  logic [AW:0]             r_n;
  logic [WW-1:0]           r_wcnt;
  logic                    r_busy;
  logic                    r_batch_done;
  logic                    r_timeout;
  logic                    r_krst;
  logic                    r_kstart;
  logic                    r_kt;
  logic signed [WIDTH-1:0] r_ka;
  logic signed [WIDTH-1:0] r_kb;
  logic signed [WIDTH-1:0] r_kc;
  logic signed [WIDTH-1:0] r_rd_z;
  logic signed [WIDTH-1:0] r_rd_x;

  logic signed [WIDTH-1:0] op_a  [DEPTH];
  logic signed [WIDTH-1:0] op_b  [DEPTH];
  logic signed [WIDTH-1:0] op_c  [DEPTH];
  logic                    op_t  [DEPTH];
  logic signed [WIDTH-1:0] res_z [DEPTH];
  logic signed [WIDTH-1:0] res_x [DEPTH];

  logic [AW:0]   w_n;
  logic [AW-1:0] w_idx_inc;
  logic          w_last;

  assign w_n       = (i_count > DEPTH_N) ? DEPTH_N : i_count;
  assign w_idx_inc = r_idx + AW'(1);
  assign w_last    = ({1'b0, r_idx} == (r_n - (AW + 1)'(1)));

  // Tables are never cleared by reset; the operand table is frozen while busy.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_wr_en && !r_busy) begin
      op_a[i_wr_addr] <= i_wr_a;
      op_b[i_wr_addr] <= i_wr_b;
      op_c[i_wr_addr] <= i_wr_c;
      op_t[i_wr_addr] <= i_wr_t;
    end
    if (i_rst_n && r_state == STORE) begin
      res_z[r_idx] <= kif.k_z;
      res_x[r_idx] <= kif.k_x;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_n          <= '0;
      r_wcnt       <= '0;
      r_busy       <= 1'b0;
      r_batch_done <= 1'b0;
      r_timeout    <= 1'b0;
      r_krst       <= 1'b0;
      r_kstart     <= 1'b0;
      r_kt         <= 1'b0;
      r_ka         <= '0;
      r_kb         <= '0;
      r_kc         <= '0;
      r_rd_z       <= '0;
      r_rd_x       <= '0;
    end else begin
      r_kstart     <= 1'b0;
      r_batch_done <= 1'b0;
      r_rd_z       <= res_z[i_rd_addr];
      r_rd_x       <= res_x[i_rd_addr];
      case (r_state)
        IDLE, ERR: begin
          if (i_go) begin
            r_n       <= w_n;
            r_timeout <= 1'b0;
            r_idx     <= '0;
            if (w_n == '0) begin
              r_batch_done <= 1'b1;
              r_krst       <= 1'b0;
              r_state      <= IDLE;
            end else begin
              r_busy  <= 1'b1;
              r_krst  <= 1'b1;
              r_ka    <= op_a[0];
              r_kb    <= op_b[0];
              r_kc    <= op_c[0];
              r_kt    <= op_t[0];
              r_state <= KRST;
            end
          end
        end
        KRST: begin
          r_krst   <= 1'b0;
          r_kstart <= 1'b1;
          r_wcnt   <= '0;
          r_state  <= ISSUE;
        end
        ISSUE: begin
          r_wcnt  <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (kif.k_done) begin
            r_state <= STORE;
          end else begin
            r_wcnt <= r_wcnt + WW'(1);
            if (r_wcnt + WW'(1) == TO_N) begin
              r_timeout <= 1'b1;
              r_busy    <= 1'b0;
              r_krst    <= 1'b1;
              r_state   <= ERR;
            end
          end
        end
        STORE: begin
          if (w_last) begin
            r_busy       <= 1'b0;
            r_batch_done <= 1'b1;
            r_state      <= FINISH;
          end else begin
            r_idx   <= w_idx_inc;
            r_krst  <= 1'b1;
            r_ka    <= op_a[w_idx_inc];
            r_kb    <= op_b[w_idx_inc];
            r_kc    <= op_c[w_idx_inc];
            r_kt    <= op_t[w_idx_inc];
            r_state <= KRST;
          end
        end
        FINISH:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_rd_z       = r_rd_z;
  assign o_rd_x       = r_rd_x;
  assign o_busy       = r_busy;
  assign o_batch_done = r_batch_done;
  assign o_timeout    = r_timeout;
  assign kif.k_rst    = r_krst;
  assign kif.k_start  = r_kstart;
  assign kif.k_a      = r_ka;
  assign kif.k_b      = r_kb;
  assign kif.k_c      = r_kc;
  assign kif.k_t      = r_kt;
  assign kif.k_zero   = '0;
  assign kif.k_one    = WIDTH'(1);
endmodule
